// File: rtl/game_sequencer_pkg.sv
// Shared state encoding, default parameters and digit helpers for the
// guessing-game sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_GUESS = 3'd2,
      ST_PULSE = 3'd3,
      ST_CHECK = 3'd4,
      ST_WIN   = 3'd5,
      ST_LOSE  = 3'd6
   } state_t;

   localparam logic [3:0]  MAX_ROUNDS_DEF = 4'd9;
   localparam logic [2:0]  MAX_MISSES_DEF = 3'd5;
   localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;

   function automatic logic [3:0] nibble_to_bcd(input logic [3:0] n);
      return (n < 4'd10) ? n : (n - 4'd6);
   endfunction

   function automatic logic [1:0] lock_digits(input logic [1:0] sel);
      return (sel == 2'd0) ? 2'd1 : sel;
   endfunction

endpackage

// File: rtl/game_sequencer_lfsr.sv
// Free-running 16-bit Fibonacci LFSR whose low three nibbles are folded
// into BCD digits for the answer.
module answer_lfsr
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] o_digit0,
   output logic [3:0] o_digit1,
   output logic [3:0] o_digit2
);

   logic [15:0] r_lfsr;
   logic        w_fb;
   logic [15:0] w_next;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign w_next = {r_lfsr[14:0], w_fb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (w_next == 16'd0) begin
         // only reachable from a zero seed; kick the register out of lock-up
         r_lfsr <= 16'h0001;
      end else begin
         r_lfsr <= w_next;
      end
   end

   assign o_digit0 = nibble_to_bcd(r_lfsr[3:0]);
   assign o_digit1 = nibble_to_bcd(r_lfsr[7:4]);
   assign o_digit2 = nibble_to_bcd(r_lfsr[11:8]);

endmodule

// File: rtl/game_sequencer.sv
// Guessing-game sequencer: button edge detect, game FSM and registered
// outputs that drive an external hint/compare block.
//  state | meaning
//  IDLE  | waiting for start, hint block held in clear
//  LOAD  | latch answer digits and the round reference
//  GUESS | waiting for a confirm press
//  PULSE | one-cycle confirm strobe to the hint block
//  CHECK | evaluate round / miss counts returned by the hint block
//  WIN   | all rounds won, waiting for start
//  LOSE  | out of lives, waiting for start
module game_sequencer
   import game_pkg::*;
#(
   parameter logic [3:0]  MAX_ROUNDS = MAX_ROUNDS_DEF,
   parameter logic [2:0]  MAX_MISSES = MAX_MISSES_DEF,
   parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       restart,
   input  logic       start_btn,
   input  logic       confirm_btn,
   input  logic [1:0] diff_sel,
   input  logic [3:0] round,
   input  logic [2:0] incorrect_guess,
   output logic [1:0] Max_digit,
   output logic [3:0] answer0,
   output logic [3:0] answer1,
   output logic [3:0] answer2,
   output logic       confirm_pulse,
   output logic       hint_restart_n,
   output logic [2:0] state,
   output logic [2:0] lives_left,
   output logic       win,
   output logic       game_over
);

   state_t     r_state;
   state_t     w_next;
   logic       r_start_q;
   logic       r_start_prev;
   logic       r_confirm_q;
   logic       r_confirm_prev;
   logic       w_start_edge;
   logic       w_confirm_edge;
   logic       w_round_moved;
   logic [3:0] w_dig0;
   logic [3:0] w_dig1;
   logic [3:0] w_dig2;
   logic [3:0] r_round_q;
   logic [1:0] r_max_digit;
   logic [3:0] r_answer0;
   logic [3:0] r_answer1;
   logic [3:0] r_answer2;
   logic       r_confirm_pulse;
   logic       r_hint_restart_n;
   logic       r_win;
   logic       r_game_over;

   answer_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk      (clk),
      .rst_n    (restart),
      .o_digit0 (w_dig0),
      .o_digit1 (w_dig1),
      .o_digit2 (w_dig2)
   );

   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         r_start_q      <= 1'b0;
         r_start_prev   <= 1'b0;
         r_confirm_q    <= 1'b0;
         r_confirm_prev <= 1'b0;
      end else begin
         r_start_q      <= start_btn;
         r_start_prev   <= r_start_q;
         r_confirm_q    <= confirm_btn;
         r_confirm_prev <= r_confirm_q;
      end
   end

   assign w_start_edge   = r_start_q & ~r_start_prev;
   assign w_confirm_edge = r_confirm_q & ~r_confirm_prev;
   assign w_round_moved  = (round != r_round_q);

   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_edge) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_GUESS;
         ST_GUESS: if (w_confirm_edge) w_next = ST_PULSE;
         ST_PULSE: w_next = ST_CHECK;
         ST_CHECK: begin
            if (w_round_moved && (round > MAX_ROUNDS)) w_next = ST_WIN;
            else if (w_round_moved)                    w_next = ST_LOAD;
            else if (incorrect_guess >= MAX_MISSES)    w_next = ST_LOSE;
            else                                       w_next = ST_GUESS;
         end
         ST_WIN:   if (w_start_edge) w_next = ST_IDLE;
         ST_LOSE:  if (w_start_edge) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Outputs decode the next state so they change on the same edge as state.
   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         r_max_digit      <= 2'd0;
         r_answer0        <= 4'd0;
         r_answer1        <= 4'd0;
         r_answer2        <= 4'd0;
         r_round_q        <= 4'd0;
         r_confirm_pulse  <= 1'b0;
         r_hint_restart_n <= 1'b0;
         r_win            <= 1'b0;
         r_game_over      <= 1'b0;
      end else begin
         r_confirm_pulse  <= (w_next == ST_PULSE);
         r_win            <= (w_next == ST_WIN);
         r_game_over      <= (w_next == ST_WIN) || (w_next == ST_LOSE);
         r_hint_restart_n <= (w_next != ST_IDLE);

         if (w_next == ST_IDLE)       r_max_digit <= 2'd0;
         else if (r_state == ST_IDLE) r_max_digit <= lock_digits(diff_sel);

         if (r_state == ST_LOAD) begin
            r_round_q <= round;
            r_answer0 <= w_dig0;
            r_answer1 <= (r_max_digit >= 2'd2) ? w_dig1 : 4'd0;
            r_answer2 <= (r_max_digit == 2'd3) ? w_dig2 : 4'd0;
         end
      end
   end

   assign lives_left     = (incorrect_guess >= MAX_MISSES) ? 3'd0 : (MAX_MISSES - incorrect_guess);
   assign state          = r_state;
   assign Max_digit      = r_max_digit;
   assign answer0        = r_answer0;
   assign answer1        = r_answer1;
   assign answer2        = r_answer2;
   assign confirm_pulse  = r_confirm_pulse;
   assign hint_restart_n = r_hint_restart_n;
   assign win            = r_win;
   assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus predicts each state change
// from the game rules, a negedge monitor pops and compares.
module tb_game_sequencer;

   localparam int MR = 9;
   localparam int MM = 5;
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_GUESS = 3'd2,
                          S_PULSE = 3'd3, S_CHECK = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;

   logic       clk = 1'b0;
   logic       restart = 1'b0;
   logic       start_btn = 1'b0;
   logic       confirm_btn = 1'b0;
   logic [1:0] diff_sel = 2'd0;
   logic [3:0] round = 4'd0;
   logic [2:0] incorrect_guess = 3'd0;
   logic [1:0] Max_digit;
   logic [3:0] answer0, answer1, answer2;
   logic       confirm_pulse, hint_restart_n, win, game_over;
   logic [2:0] state, lives_left;

   always #5 clk = ~clk;

   game_sequencer #(.MAX_ROUNDS(4'd9), .MAX_MISSES(3'd5), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .restart(restart), .start_btn(start_btn), .confirm_btn(confirm_btn),
      .diff_sel(diff_sel), .round(round), .incorrect_guess(incorrect_guess),
      .Max_digit(Max_digit), .answer0(answer0), .answer1(answer1), .answer2(answer2),
      .confirm_pulse(confirm_pulse), .hint_restart_n(hint_restart_n), .state(state),
      .lives_left(lives_left), .win(win), .game_over(game_over)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] md;
      logic       chk;
   } exp_t;

   exp_t expq[$];
   int   n_total = 0;
   int   n_bad = 0;
   int   pulse_cnt = 0;
   int   exp_pulses = 0;

   // game model
   int         g_round, g_ig, g_rq;
   logic [1:0] g_md;
   bit         g_done;

   // reference LFSR: value held during the current cycle and the one before
   logic [15:0] m_lfsr, m_prev;
   always @(posedge clk or negedge restart) begin
      if (!restart) begin
         m_lfsr <= 16'hACE1;
         m_prev <= 16'hACE1;
      end else begin
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         m_prev <= m_lfsr;
      end
   end

   function automatic logic [3:0] digit_of(input logic [3:0] n);
      int v;
      v = int'(n);
      if (v >= 10) v = v - 6;
      return v[3:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [1:0] md, input logic chk);
      exp_t e;
      e.st = st;
      e.md = md;
      e.chk = chk;
      expq.push_back(e);
   endtask

   // monitor
   initial begin
      logic [2:0]  prev_st;
      exp_t        e;
      logic [11:0] exp_ans;
      prev_st = S_IDLE;
      forever begin
         @(negedge clk);
         if (confirm_pulse) pulse_cnt++;
         if (state !== prev_st) begin
            if (expq.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_transition: state %0d, nothing expected", state);
            end else begin
               e = expq.pop_front();
               check("state", 32'(state), 32'(e.st));
               check("win_over_hint_md", 32'({win, game_over, hint_restart_n, Max_digit}),
                     32'({e.st == S_WIN, (e.st == S_WIN) || (e.st == S_LOSE), e.st != S_IDLE, e.md}));
               if (e.st == S_PULSE) check("pulse_in_PULSE", 32'(confirm_pulse), 32'd1);
               if (e.chk) begin
                  exp_ans[3:0]  = digit_of(m_prev[3:0]);
                  exp_ans[7:4]  = (e.md >= 2'd2) ? digit_of(m_prev[7:4]) : 4'd0;
                  exp_ans[11:8] = (e.md == 2'd3) ? digit_of(m_prev[11:8]) : 4'd0;
                  check("answers", 32'({answer2, answer1, answer0}), 32'(exp_ans));
                  check("digits_bcd", 32'((answer0 <= 9) && (answer1 <= 9) && (answer2 <= 9)), 32'd1);
               end
            end
         end
         prev_st = state;
      end
   end

   task automatic set_inputs(input int r, input int ig);
      int exp_l;
      @(negedge clk);
      round = r[3:0];
      incorrect_guess = ig[2:0];
      #1;
      exp_l = (ig >= MM) ? 0 : MM - ig;
      check("lives_left", 32'(lives_left), 32'(exp_l));
   endtask

   task automatic press(input logic s, input logic c, input int hold);
      @(negedge clk);
      start_btn = s;
      confirm_btn = c;
      repeat (hold) @(negedge clk);
      start_btn = 1'b0;
      confirm_btn = 1'b0;
      repeat (8 + $urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic start_game(input logic [1:0] diff, input int r0);
      set_inputs(r0, 0);
      diff_sel = diff;
      g_round = r0;
      g_ig = 0;
      g_rq = r0;
      g_done = 1'b0;
      g_md = (diff == 2'd0) ? 2'd1 : diff;
      push(S_LOAD, g_md, 1'b0);
      push(S_GUESS, g_md, 1'b1);
      press(1'b1, 1'b0, 1);
   endtask

   task automatic end_game();
      push(S_IDLE, 2'd0, 1'b0);
      press(1'b1, 1'b0, 1);
   endtask

   task automatic do_guess(input bit hit, input int hold, input logic with_start);
      if (hit) g_round++;
      else     g_ig++;
      set_inputs(g_round, g_ig);
      push(S_PULSE, g_md, 1'b0);
      push(S_CHECK, g_md, 1'b0);
      exp_pulses++;
      if (g_round != g_rq && g_round > MR) begin
         push(S_WIN, g_md, 1'b0);
         g_done = 1'b1;
      end else if (g_round != g_rq) begin
         push(S_LOAD, g_md, 1'b0);
         push(S_GUESS, g_md, 1'b1);
         g_rq = g_round;
      end else if (g_ig >= MM) begin
         push(S_LOSE, g_md, 1'b0);
         g_done = 1'b1;
      end else begin
         push(S_GUESS, g_md, 1'b0);
      end
      press(with_start, 1'b1, hold);
   endtask

   task automatic restart_in_check();
      bit found;
      set_inputs(g_round, g_ig);
      push(S_PULSE, g_md, 1'b0);
      push(S_CHECK, g_md, 1'b0);
      push(S_IDLE, 2'd0, 1'b0);
      exp_pulses++;
      @(negedge clk);
      confirm_btn = 1'b1;
      @(negedge clk);
      confirm_btn = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (state == S_CHECK) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_total++;
         n_bad++;
         $display("FAIL reach_check: state %0d, CHECK required within 10 cycles", state);
      end
      #1 restart = 1'b0;
      #1;
      check("async_rst_state", 32'(state), 32'(S_IDLE));
      check("async_rst_hint", 32'(hint_restart_n), 32'd0);
      check("async_rst_pulse", 32'(confirm_pulse), 32'd0);
      check("async_rst_md", 32'(Max_digit), 32'd0);
      repeat (2) @(negedge clk);
      #2 restart = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int p0;
      int guard;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(state), 32'(S_IDLE));
      check("rst_md", 32'(Max_digit), 32'd0);
      check("rst_answers", 32'({answer2, answer1, answer0}), 32'd0);
      check("rst_pulse", 32'(confirm_pulse), 32'd0);
      check("rst_hint", 32'(hint_restart_n), 32'd0);
      check("rst_win", 32'(win), 32'd0);
      check("rst_over", 32'(game_over), 32'd0);
      #2 restart = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_rst", 32'(state), 32'(S_IDLE));

      // seed/mapping after a random wait, then lose path
      repeat ($urandom_range(3, 40)) @(negedge clk);
      start_game(2'd3, 1);
      for (int i = 0; i < MM; i++) do_guess(1'b0, 1, 1'b0);
      check("lost_flag", 32'({win, game_over}), 32'b01);
      press(1'b0, 1'b1, 3);
      end_game();

      // difficulty 0, long confirm hold, simultaneous start+confirm, reset in CHECK
      start_game(2'd0, 3);
      p0 = pulse_cnt;
      do_guess(1'b0, 10, 1'b0);
      check("one_pulse_hold", 32'(pulse_cnt - p0), 32'd1);
      do_guess(1'b0, 1, 1'b1);
      restart_in_check();

      // win path: round 1..10
      start_game(2'd2, 1);
      for (int i = 0; i < MR; i++) do_guess(1'b1, 1, 1'b0);
      check("won_flag", 32'({win, game_over}), 32'b11);
      press(1'b0, 1'b1, 2);
      end_game();

      // randomized games
      for (int g = 0; g < 4; g++) begin
         start_game(2'($urandom_range(0, 3)), $urandom_range(0, 4));
         guard = 0;
         while (!g_done && guard < 60) begin
            guard++;
            if ($urandom_range(0, 9) == 0) press(1'b1, 1'b0, 1);
            else do_guess(1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0);
         end
         if ($urandom_range(0, 1) == 1) press(1'b0, 1'b1, 2);
         end_game();
      end

      set_inputs(0, 6);
      set_inputs(0, 7);
      repeat (10) @(negedge clk);
      check("queue_drained", 32'(expq.size()), 32'd0);
      check("pulse_total", 32'(pulse_cnt), 32'(exp_pulses));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run still active at %0t, finish required earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
